// File: rtl/imem_arbiter_if.sv
// Handshake and memory-port bundle between the fetch/debug requesters, the arbiter and the instruction memory.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface imem_arbiter_if;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        f_gnt_o;
  logic        f_valid_o;
  logic [31:0] f_instr_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic        d_gnt_o;
  logic        d_valid_o;
  logic [31:0] d_instr_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_instr_i;
  logic        err_o;

  modport slave (
    input  f_req_i, f_addr_i, d_req_i, d_addr_i, mem_instr_i,
    output f_gnt_o, f_valid_o, f_instr_o, d_gnt_o, d_valid_o, d_instr_o,
    output mem_addr_o, err_o
  );

  modport master (
    output f_req_i, f_addr_i, d_req_i, d_addr_i, mem_instr_i,
    input  f_gnt_o, f_valid_o, f_instr_o, d_gnt_o, d_valid_o, d_instr_o,
    input  mem_addr_o, err_o
  );
endinterface

// File: rtl/imem_arbiter.sv
// Fixed-priority fetch/debug arbiter for the imem read port; grant is combinational, response 1 cycle later.
// A starvation counter forces a debug grant after MAX_FGNT fetch wins; `IMEM_ARB_ALIGN_CHK_EN adds a misalignment check.
module imem_arbiter #(
  parameter int unsigned MAX_FGNT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RSP_F, RSP_D} rsp_st_t;

  rsp_st_t     rsp_st;
  rsp_st_t     rsp_nxt;
  logic [3:0]  starve;
  logic [3:0]  starve_nxt;
  logic        f_gnt;
  logic        d_gnt;
  logic        starved;
  logic [31:0] mem_addr;
  logic [31:0] rsp_word;
  logic [31:0] f_instr_q;
  logic [31:0] d_instr_q;

  assign starved = (starve == MAX_FGNT[3:0]);

  always_comb begin
    d_gnt    = bus.d_req_i & (~bus.f_req_i | starved);
    f_gnt    = bus.f_req_i & ~d_gnt;
    mem_addr = 32'h0;
    if (d_gnt)
      mem_addr = bus.d_addr_i;
    else if (f_gnt)
      mem_addr = bus.f_addr_i;
  end

  // Counter only advances while debug is actually waiting behind a fetch.
  always_comb begin
    starve_nxt = starve;
    if (d_gnt || !bus.d_req_i)
      starve_nxt = 4'd0;
    else if (f_gnt && !starved)
      starve_nxt = starve + 4'd1;
  end

  always_comb begin
    rsp_nxt = IDLE;
    if (f_gnt)
      rsp_nxt = RSP_F;
    else if (d_gnt)
      rsp_nxt = RSP_D;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_st <= IDLE;
      starve <= 4'd0;
    end else begin
      rsp_st <= rsp_nxt;
      starve <= starve_nxt;
    end
  end

`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic misaligned;
  logic err_q;

  assign misaligned = |mem_addr[1:0];
  assign rsp_word   = misaligned ? 32'h0 : bus.mem_instr_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      err_q <= 1'b0;
    else
      err_q <= (f_gnt | d_gnt) & misaligned;
  end

  assign bus.err_o = err_q;
`else
  assign rsp_word  = bus.mem_instr_i;
  assign bus.err_o = 1'b0;
`endif

  // Only the granted side captures; the other keeps its last word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      f_instr_q <= 32'h0;
      d_instr_q <= 32'h0;
    end else begin
      if (f_gnt)
        f_instr_q <= rsp_word;
      if (d_gnt)
        d_instr_q <= rsp_word;
    end
  end

  assign bus.f_gnt_o    = f_gnt;
  assign bus.d_gnt_o    = d_gnt;
  assign bus.mem_addr_o = mem_addr;
  assign bus.f_valid_o  = (rsp_st == RSP_F);
  assign bus.d_valid_o  = (rsp_st == RSP_D);
  assign bus.f_instr_o  = f_instr_q;
  assign bus.d_instr_o  = d_instr_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reset, fetch stream, debug access, starvation rotation, misaligned access.
// Inputs change 1ns after the rising edge; combinational outputs are checked 1ns later, registered ones right after the edge.
module tb_imem_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  imem_arbiter_if bus ();

  imem_arbiter #(.MAX_FGNT(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h0000_0000: memw = 32'h0000_0011;
      32'h0000_0004: memw = 32'h0000_0022;
      32'h0000_0008: memw = 32'h0000_0033;
      32'h0000_0010: memw = 32'hCAFE_0010;
      default:       memw = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always_comb bus.mem_instr_i = memw(bus.mem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f_exp [3];
    logic        exp_d;
    n_chk  = 0;
    n_fail = 0;
    f_exp[0] = 32'h11;
    f_exp[1] = 32'h22;
    f_exp[2] = 32'h33;

    rst_n        = 1'b0;
    bus.f_req_i  = 1'b0;
    bus.f_addr_i = 32'h0;
    bus.d_req_i  = 1'b0;
    bus.d_addr_i = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_valid", 32'(bus.f_valid_o), 32'd0);
    chk("rst_d_valid", 32'(bus.d_valid_o), 32'd0);
    chk("rst_err",     32'(bus.err_o),     32'd0);
    chk("rst_f_instr", bus.f_instr_o,      32'h0);
    chk("rst_d_instr", bus.d_instr_o,      32'h0);
    chk("rst_starve",  32'(dut.starve),    32'd0);
    chk("rst_mem_addr", bus.mem_addr_o,    32'h0);
    rst_n = 1'b1;

    // Fetch-only stream, one word per cycle
    tick;
    bus.f_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.f_addr_i = 32'(i * 4);
      #1;
      chk("fo_f_gnt",    32'(bus.f_gnt_o), 32'd1);
      chk("fo_d_gnt",    32'(bus.d_gnt_o), 32'd0);
      chk("fo_mem_addr", bus.mem_addr_o,   32'(i * 4));
      tick;
      chk("fo_f_valid",  32'(bus.f_valid_o), 32'd1);
      chk("fo_d_valid",  32'(bus.d_valid_o), 32'd0);
      chk("fo_f_instr",  bus.f_instr_o,      f_exp[i]);
    end
    bus.f_req_i = 1'b0;
    #1;
    chk("fo_idle_gnt",  32'(bus.f_gnt_o), 32'd0);
    chk("fo_idle_addr", bus.mem_addr_o,   32'h0);
    tick;
    chk("fo_end_valid", 32'(bus.f_valid_o), 32'd0);
    chk("fo_hold_instr", bus.f_instr_o,     32'h33);

    // Reset asserted while a response is pending
    bus.f_req_i  = 1'b1;
    bus.f_addr_i = 32'h4;
    tick;
    chk("mr_valid_pre", 32'(bus.f_valid_o), 32'd1);
    bus.f_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_valid_kill", 32'(bus.f_valid_o), 32'd0);
    chk("mr_instr_clr",  bus.f_instr_o,      32'h0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("mr_post1_valid", 32'(bus.f_valid_o), 32'd0);
    tick;
    chk("mr_post2_valid", 32'(bus.f_valid_o), 32'd0);

    // Debug-only access
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h10;
    #1;
    chk("do_d_gnt",    32'(bus.d_gnt_o), 32'd1);
    chk("do_f_gnt",    32'(bus.f_gnt_o), 32'd0);
    chk("do_mem_addr", bus.mem_addr_o,   32'h10);
    tick;
    bus.d_req_i = 1'b0;
    chk("do_d_valid", 32'(bus.d_valid_o), 32'd1);
    chk("do_f_valid", 32'(bus.f_valid_o), 32'd0);
    chk("do_d_instr", bus.d_instr_o,      32'hCAFE_0010);
    chk("do_err",     32'(bus.err_o),     32'd0);
    tick;
    chk("do_end_valid", 32'(bus.d_valid_o), 32'd0);

    // Simultaneous arrival then sustained contention: F,F,F,F,D repeating
    bus.f_req_i  = 1'b1;
    bus.f_addr_i = 32'h20;
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h24;
    #1;
    chk("sim_starve0", 32'(dut.starve), 32'd0);
    for (int i = 0; i < 10; i++) begin
      exp_d = ((i % 5) == 4);
      chk("st_d_gnt",    32'(bus.d_gnt_o), 32'(exp_d));
      chk("st_f_gnt",    32'(bus.f_gnt_o), 32'(!exp_d));
      chk("st_mem_addr", bus.mem_addr_o,   exp_d ? 32'h24 : 32'h20);
      tick;
      chk("st_f_valid", 32'(bus.f_valid_o), 32'(!exp_d));
      chk("st_d_valid", 32'(bus.d_valid_o), 32'(exp_d));
      chk("st_starve",  32'(dut.starve),    exp_d ? 32'd0 : 32'((i % 5) + 1));
      if (exp_d)
        chk("st_d_instr", bus.d_instr_o, 32'hA5A5_0024);
      #1;
    end
    bus.f_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    tick;
    chk("st_idle_starve", 32'(dut.starve), 32'd0);

    // Misaligned debug address
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h6;
    #1;
    chk("mis_mem_addr", bus.mem_addr_o, 32'h6);
    tick;
    bus.d_req_i = 1'b0;
    chk("mis_d_valid", 32'(bus.d_valid_o), 32'd1);
`ifdef IMEM_ARB_ALIGN_CHK_EN
    chk("mis_d_instr", bus.d_instr_o,  32'h0);
    chk("mis_err",     32'(bus.err_o), 32'd1);
`else
    chk("mis_d_instr", bus.d_instr_o,  32'hA5A5_0006);
    chk("mis_err",     32'(bus.err_o), 32'd0);
`endif
    tick;
    chk("mis_err_end",   32'(bus.err_o),     32'd0);
    chk("mis_valid_end", 32'(bus.d_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
